// File: rtl/evt_capture_pkg.sv
// Shared definitions for the event recorder: log2 helper, event-word field
// offsets and the one-shot capture state encoding.
package evt_capture_pkg;

   typedef enum logic [1:0] {
      OS_IDLE  = 2'd0,
      OS_ARMED = 2'd1,
      OS_DONE  = 2'd2
   } os_state_t;

   // Ceiling log2 with a floor of 1 so single-entry fields keep one bit.
   function automatic int f_log2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int f_val_lsb(input int ts_w);
      return ts_w;
   endfunction

   function automatic int f_id_lsb(input int ts_w, input int val_w);
      return ts_w + val_w;
   endfunction

   function automatic int f_ch_lsb(input int ts_w, input int val_w, input int id_w);
      return ts_w + val_w + id_w;
   endfunction

endpackage

// File: rtl/evt_rcrdr_mc_if.sv
// Control, channel and FIFO-drain signals of the event recorder.
// The master side drives controls and strobes; the slave side is the recorder.
interface evt_rcrdr_mc_if
   import evt_capture_pkg::*;
#(
   parameter int DATA_WIDTH         = 64,
   parameter int NUM_MONITORED_SIGS = 4,
   parameter int SIGNAL_ID_SIZE     = 3,
   parameter int SIG_VALUE_SIZE     = 8,
   parameter int TIMER_RES_SIZE     = 3,
   parameter int FIFO_DEPTH         = 16,
   parameter int DROP_CNT_WIDTH     = 16
) ();

   logic                                         enable_events;
   logic                                         oneshot_mode;
   logic                                         arm;
   logic                                         reset_timers;
   logic                                         drop_cnt_clr;
   logic [TIMER_RES_SIZE-1:0]                    tmr_resolution;
   logic [NUM_MONITORED_SIGS-1:0]                monitor_mask;
   logic [NUM_MONITORED_SIGS-1:0]                signals;
   logic [SIG_VALUE_SIZE*NUM_MONITORED_SIGS-1:0] signal_values;
   logic [SIGNAL_ID_SIZE*NUM_MONITORED_SIGS-1:0] signal_ids;
   logic                                         evt_fifo_rd_en;
   logic [DATA_WIDTH-1:0]                        event_data;
   logic                                         evt_fifo_empty;
   logic [f_log2(FIFO_DEPTH):0]                  evt_fifo_count;
   logic [DROP_CNT_WIDTH-1:0]                    evts_dropped;
   logic                                         capture_done;

   modport master (
      output enable_events, oneshot_mode, arm, reset_timers, drop_cnt_clr,
             tmr_resolution, monitor_mask, signals, signal_values, signal_ids,
             evt_fifo_rd_en,
      input  event_data, evt_fifo_empty, evt_fifo_count, evts_dropped, capture_done
   );

   modport slave (
      input  enable_events, oneshot_mode, arm, reset_timers, drop_cnt_clr,
             tmr_resolution, monitor_mask, signals, signal_values, signal_ids,
             evt_fifo_rd_en,
      output event_data, evt_fifo_empty, evt_fifo_count, evts_dropped, capture_done
   );

endinterface

// File: rtl/evt_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head word and exact
// occupancy count. The caller must not write when full unless it also pops.
module evt_sync_fifo
   import evt_capture_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_dat,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_dat,
   output logic                     o_empty,
   output logic [f_log2(DEPTH):0]   o_count
);

   localparam int AW = f_log2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    w_rd_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dout;
   logic             w_rd;

   assign w_rd     = i_rd_en && (r_cnt != '0);
   assign w_rd_nxt = r_rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_dout   <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd)    r_rd_ptr <= w_rd_nxt;
         r_cnt <= r_cnt + CW'(i_wr_en) - CW'(w_rd);
         // Head register: next stored word, or the incoming word when it becomes the head.
         if (w_rd) begin
            if (r_cnt > CW'(1))  r_dout <= r_mem[w_rd_nxt];
            else if (i_wr_en)    r_dout <= i_wr_dat;
         end else if (i_wr_en && (r_cnt == '0)) begin
            r_dout <= i_wr_dat;
         end
      end
   end

   assign o_rd_dat = r_dout;
   assign o_empty  = (r_cnt == '0);
   assign o_count  = r_cnt;

endmodule

// File: rtl/evt_rcrdr_mc.sv
// Multi-channel event recorder: timestamps channel strobes, keeps one word per
// cycle in an FWFT FIFO, counts lost events, and supports one-shot capture.
module evt_rcrdr_mc
   import evt_capture_pkg::*;
#(
   parameter int DATA_WIDTH         = 64,
   parameter int NUM_MONITORED_SIGS = 4,
   parameter int SIGNAL_ID_SIZE     = 3,
   parameter int SIG_VALUE_SIZE     = 8,
   parameter int TIMER_RES_SIZE     = 3,
   parameter int TS_WIDTH           = 32,
   parameter int FIFO_DEPTH         = 16,
   parameter int DROP_CNT_WIDTH     = 16
) (
   input  logic          clk,
   input  logic          reset,
   evt_rcrdr_mc_if.slave bus
);

   localparam int CH_W    = f_log2(NUM_MONITORED_SIGS);
   localparam int NC_W    = CH_W + 1;
   localparam int CNT_W   = f_log2(FIFO_DEPTH) + 1;
   localparam int PW      = 1 << TIMER_RES_SIZE;
   localparam int VAL_LSB = f_val_lsb(TS_WIDTH);
   localparam int ID_LSB  = f_id_lsb(TS_WIDTH, SIG_VALUE_SIZE);
   localparam int CH_LSB  = f_ch_lsb(TS_WIDTH, SIG_VALUE_SIZE, SIGNAL_ID_SIZE);
   localparam int SUM_W   = ((DROP_CNT_WIDTH > NC_W) ? DROP_CNT_WIDTH : NC_W) + 1;
   localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

   if (TS_WIDTH + SIG_VALUE_SIZE + SIGNAL_ID_SIZE + CH_W > DATA_WIDTH) begin : g_width_chk
      $error("evt_rcrdr_mc: event fields do not fit in DATA_WIDTH");
   end

   logic [PW-1:0]                 r_presc;
   logic [PW-1:0]                 w_presc_max;
   logic [TS_WIDTH-1:0]           r_ts;
   logic                          w_active;
   logic [NUM_MONITORED_SIGS-1:0] w_cand;
   logic                          w_win_vld;
   logic [CH_W-1:0]               w_win_idx;
   logic [NC_W-1:0]               w_n_cand;
   logic [NC_W-1:0]               w_n_drop;
   logic [DATA_WIDTH-1:0]         w_word;
   logic [CNT_W-1:0]              w_cnt;
   logic [CNT_W-1:0]              w_cnt_next;
   logic                          w_empty;
   logic                          w_full;
   logic                          w_pop;
   logic                          w_wr;
   logic [SUM_W-1:0]              w_drop_sum;
   logic [DROP_CNT_WIDTH-1:0]     r_drop;
   os_state_t                     r_state;
   logic                          r_done;

   assign w_presc_max = (PW'(1) << bus.tmr_resolution) - PW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_ts    <= '0;
      end else if (bus.reset_timers) begin
         r_presc <= '0;
         r_ts    <= '0;
      end else if (r_presc == w_presc_max) begin
         r_presc <= '0;
         r_ts    <= r_ts + TS_WIDTH'(1);
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   assign w_active = bus.enable_events && (!bus.oneshot_mode || (r_state == OS_ARMED));
   assign w_cand   = w_active ? (bus.signals & bus.monitor_mask) : '0;

   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = '0;
      w_n_cand  = '0;
      for (int i = 0; i < NUM_MONITORED_SIGS; i++) begin
         if (w_cand[i]) begin
            if (!w_win_vld) begin
               w_win_vld = 1'b1;
               w_win_idx = CH_W'(i);
            end
            w_n_cand = w_n_cand + NC_W'(1);
         end
      end
   end

   always_comb begin
      w_word                             = '0;
      w_word[TS_WIDTH-1:0]               = r_ts;
      w_word[VAL_LSB +: SIG_VALUE_SIZE]  = bus.signal_values[int'(w_win_idx)*SIG_VALUE_SIZE +: SIG_VALUE_SIZE];
      w_word[ID_LSB +: SIGNAL_ID_SIZE]   = bus.signal_ids[int'(w_win_idx)*SIGNAL_ID_SIZE +: SIGNAL_ID_SIZE];
      w_word[CH_LSB +: CH_W]             = w_win_idx;
   end

   // A pop in the same cycle frees the slot the winner needs, even when full.
   assign w_full     = (w_cnt == CNT_W'(FIFO_DEPTH));
   assign w_pop      = bus.evt_fifo_rd_en && !w_empty;
   assign w_wr       = w_win_vld && (!w_full || w_pop);
   assign w_cnt_next = w_cnt + CNT_W'(w_wr) - CNT_W'(w_pop);
   assign w_n_drop   = w_n_cand - NC_W'(w_wr);
   assign w_drop_sum = SUM_W'(r_drop) + SUM_W'(w_n_drop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   r_drop <= '0;
      else if (bus.drop_cnt_clr || bus.arm)        r_drop <= '0;
      else if (w_drop_sum > SUM_W'(DROP_MAX))      r_drop <= DROP_MAX;
      else                                         r_drop <= w_drop_sum[DROP_CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= OS_IDLE;
         r_done  <= 1'b0;
      end else if (!bus.oneshot_mode) begin
         r_state <= OS_IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            OS_IDLE: begin
               if (bus.arm) r_state <= OS_ARMED;
               r_done <= 1'b0;
            end
            OS_ARMED: begin
               if (bus.arm) begin
                  r_state <= OS_ARMED;
                  r_done  <= 1'b0;
               end else if (w_cnt_next == CNT_W'(FIFO_DEPTH)) begin
                  r_state <= OS_DONE;
                  r_done  <= 1'b1;
               end
            end
            OS_DONE: begin
               if (bus.arm) begin
                  r_state <= OS_ARMED;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= OS_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   evt_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .i_wr_en  (w_wr),
      .i_wr_dat (w_word),
      .i_rd_en  (bus.evt_fifo_rd_en),
      .o_rd_dat (bus.event_data),
      .o_empty  (w_empty),
      .o_count  (w_cnt)
   );

   assign bus.evt_fifo_empty = w_empty;
   assign bus.evt_fifo_count = w_cnt;
   assign bus.evts_dropped   = r_drop;
   assign bus.capture_done   = r_done;

endmodule
